// File: rtl/conv_sweep_pkg.sv
// Shared definitions for the 3x3 convolution sweep controller: FSM states,
// kernel/image geometry constants and stride normalisation.
package conv_sweep_pkg;

  localparam int K_EDGE     = 3;
  localparam int IMG_MAX_PX = 32;
  localparam int TAPS       = 9;
  // Wide enough that base + stride + kernel edge never wraps.
  localparam int IDX_W      = 7;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    EMIT,
    ADV,
    FIN
  } state_e;

  function automatic logic [2:0] eff_stride(input logic [2:0] s);
    return (s == 3'd0) ? 3'd1 : s;
  endfunction

endpackage

// File: rtl/conv_win_counter.sv
// Nested window position counter: column inside row inside layer. Tracks both
// the output-grid index and the pixel base (index * stride) of each window.
module conv_win_counter
  import conv_sweep_pkg::*;
#(
  parameter int PIX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             step_i,
  input  logic [5:0]       img_h_i,
  input  logic [5:0]       img_w_i,
  input  logic [5:0]       layers_i,
  input  logic [2:0]       sx_i,
  input  logic [2:0]       sy_i,
  output logic [IDX_W-1:0] row_base_o,
  output logic [IDX_W-1:0] col_base_o,
  output logic [PIX_W-1:0] out_row_o,
  output logic [PIX_W-1:0] out_col_o,
  output logic [5:0]       layer_o,
  output logic             col_last_o,
  output logic             row_last_o,
  output logic             layer_last_o
);

  logic [IDX_W-1:0] row_base_q, row_base_d;
  logic [IDX_W-1:0] col_base_q, col_base_d;
  logic [PIX_W-1:0] out_row_q, out_row_d;
  logic [PIX_W-1:0] out_col_q, out_col_d;
  logic [5:0]       layer_q, layer_d;

  // A window is the last of its row/column when the next one would overhang the image.
  assign col_last_o   = (col_base_q + IDX_W'(sx_i) + IDX_W'(K_EDGE)) > IDX_W'(img_w_i);
  assign row_last_o   = (row_base_q + IDX_W'(sy_i) + IDX_W'(K_EDGE)) > IDX_W'(img_h_i);
  assign layer_last_o = (IDX_W'(layer_q) + IDX_W'(1)) == IDX_W'(layers_i);

  always_comb begin
    row_base_d = row_base_q;
    col_base_d = col_base_q;
    out_row_d  = out_row_q;
    out_col_d  = out_col_q;
    layer_d    = layer_q;
    if (clear_i) begin
      row_base_d = '0;
      col_base_d = '0;
      out_row_d  = '0;
      out_col_d  = '0;
      layer_d    = '0;
    end else if (step_i) begin
      if (!col_last_o) begin
        col_base_d = col_base_q + IDX_W'(sx_i);
        out_col_d  = out_col_q + PIX_W'(1);
      end else begin
        col_base_d = '0;
        out_col_d  = '0;
        if (!row_last_o) begin
          row_base_d = row_base_q + IDX_W'(sy_i);
          out_row_d  = out_row_q + PIX_W'(1);
        end else begin
          row_base_d = '0;
          out_row_d  = '0;
          layer_d    = layer_q + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_base_q <= '0;
      col_base_q <= '0;
      out_row_q  <= '0;
      out_col_q  <= '0;
      layer_q    <= '0;
    end else begin
      row_base_q <= row_base_d;
      col_base_q <= col_base_d;
      out_row_q  <= out_row_d;
      out_col_q  <= out_col_d;
      layer_q    <= layer_d;
    end
  end

  assign row_base_o = row_base_q;
  assign col_base_o = col_base_q;
  assign out_row_o  = out_row_q;
  assign out_col_o  = out_col_q;
  assign layer_o    = layer_q;

endmodule

// File: rtl/conv_sweep_ctrl.sv
// Convolution sweep controller: walks a 3x3 kernel over every output window of
// every layer, sequencing MAC clear/enable and a valid/ready result handshake.
module conv_sweep_ctrl
  import conv_sweep_pkg::*;
#(
  parameter int IMG_MAX = IMG_MAX_PX,
  parameter int K       = K_EDGE,
  localparam int PIX_W  = $clog2(IMG_MAX)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       img_h,
  input  logic [5:0]       img_w,
  input  logic [2:0]       stride_x,
  input  logic [2:0]       stride_y,
  input  logic [5:0]       num_of_conv_layers,
  input  logic             relu,
  input  logic             out_ready,
  output logic             busy,
  output logic [5:0]       layer_idx,
  output logic [PIX_W-1:0] pix_row,
  output logic [PIX_W-1:0] pix_col,
  output logic [1:0]       k_row,
  output logic [1:0]       k_col,
  output logic             mac_clr,
  output logic             mac_en,
  output logic             acc_valid,
  output logic [PIX_W-1:0] out_row,
  output logic [PIX_W-1:0] out_col,
  output logic             relu_en,
  output logic             done,
  output logic             cfg_err
);

  state_e state_q, state_d;

  logic [5:0] img_h_q, img_h_d;
  logic [5:0] img_w_q, img_w_d;
  logic [5:0] layers_q, layers_d;
  logic [2:0] sx_q, sx_d;
  logic [2:0] sy_q, sy_d;
  logic       relu_q, relu_d;
  logic       cfg_err_q, cfg_err_d;
  logic [1:0] k_row_q, k_row_d;
  logic [1:0] k_col_q, k_col_d;
  logic [3:0] tap_q, tap_d;

  logic             win_clear, win_step;
  logic [IDX_W-1:0] row_base, col_base;
  logic             col_last, row_last, layer_last;
  logic             cfg_bad;

  conv_win_counter #(.PIX_W(PIX_W)) u_win (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (win_clear),
    .step_i      (win_step),
    .img_h_i     (img_h_q),
    .img_w_i     (img_w_q),
    .layers_i    (layers_q),
    .sx_i        (sx_q),
    .sy_i        (sy_q),
    .row_base_o  (row_base),
    .col_base_o  (col_base),
    .out_row_o   (out_row),
    .out_col_o   (out_col),
    .layer_o     (layer_idx),
    .col_last_o  (col_last),
    .row_last_o  (row_last),
    .layer_last_o(layer_last)
  );

  assign cfg_bad = (img_h_q < 6'd3) || (img_w_q < 6'd3) || (layers_q == 6'd0);

  always_comb begin
    // NOTE: every signal gets a default first, so no branch can infer a latch.
    state_d   = state_q;
    img_h_d   = img_h_q;
    img_w_d   = img_w_q;
    layers_d  = layers_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    relu_d    = relu_q;
    cfg_err_d = cfg_err_q;
    k_row_d   = k_row_q;
    k_col_d   = k_col_q;
    tap_d     = tap_q;
    win_clear = 1'b0;
    win_step  = 1'b0;
    busy      = (state_q != IDLE);
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    acc_valid = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          img_h_d   = img_h;
          img_w_d   = img_w;
          layers_d  = num_of_conv_layers;
          sx_d      = eff_stride(stride_x);
          sy_d      = eff_stride(stride_y);
          relu_d    = relu;
          cfg_err_d = 1'b0;
          win_clear = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        mac_clr = 1'b1;
        k_row_d = '0;
        k_col_d = '0;
        tap_d   = '0;
        if (cfg_bad) begin
          cfg_err_d = 1'b1;
          state_d   = FIN;
        end else begin
          state_d = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (tap_q == 4'(TAPS - 1)) begin
          k_row_d = '0;
          k_col_d = '0;
          tap_d   = '0;
          state_d = EMIT;
        end else begin
          tap_d = tap_q + 4'd1;
          if (k_col_q == 2'(K - 1)) begin
            k_col_d = '0;
            k_row_d = k_row_q + 2'd1;
          end else begin
            k_col_d = k_col_q + 2'd1;
          end
        end
      end
      EMIT: begin
        acc_valid = 1'b1;
        if (out_ready) state_d = ADV;
      end
      ADV: begin
        win_step = 1'b1;
        state_d  = (col_last && row_last && layer_last) ? FIN : LOAD;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      img_h_q   <= '0;
      img_w_q   <= '0;
      layers_q  <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      relu_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      k_row_q   <= '0;
      k_col_q   <= '0;
      tap_q     <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q   <= state_d;
      img_h_q   <= img_h_d;
      img_w_q   <= img_w_d;
      layers_q  <= layers_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      relu_q    <= relu_d;
      cfg_err_q <= cfg_err_d;
      k_row_q   <= k_row_d;
      k_col_q   <= k_col_d;
      tap_q     <= tap_d;
    end
  end

  assign k_row   = k_row_q;
  assign k_col   = k_col_q;
  assign cfg_err = cfg_err_q;
  assign relu_en = busy & relu_q;
  assign pix_row = PIX_W'(row_base + IDX_W'(k_row_q));
  assign pix_col = PIX_W'(col_base + IDX_W'(k_col_q));

endmodule

// File: tb/tb_conv_sweep_ctrl.sv
// Self-checking bench: builds the expected per-cycle output trace of each run
// from window/tap loops and compares the controller against it every cycle.
module tb_conv_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [5:0] img_h, img_w, num_of_conv_layers;
  logic [2:0] stride_x, stride_y;
  logic       relu, out_ready;
  logic       busy, mac_clr, mac_en, acc_valid, relu_en, done, cfg_err;
  logic [5:0] layer_idx;
  logic [4:0] pix_row, pix_col, out_row, out_col;
  logic [1:0] k_row, k_col;

  always #5 clk = ~clk;

  conv_sweep_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .img_h             (img_h),
    .img_w             (img_w),
    .stride_x          (stride_x),
    .stride_y          (stride_y),
    .num_of_conv_layers(num_of_conv_layers),
    .relu              (relu),
    .out_ready         (out_ready),
    .busy              (busy),
    .layer_idx         (layer_idx),
    .pix_row           (pix_row),
    .pix_col           (pix_col),
    .k_row             (k_row),
    .k_col             (k_col),
    .mac_clr           (mac_clr),
    .mac_en            (mac_en),
    .acc_valid         (acc_valid),
    .out_row           (out_row),
    .out_col           (out_col),
    .relu_en           (relu_en),
    .done              (done),
    .cfg_err           (cfg_err)
  );

  typedef struct {
    int ready, busy, clr, en, av, done, err, relu;
    int pos_care, pix_care, layer, orow, ocol, prow, pcol, kr, kc;
  } exp_t;

  exp_t tq[$];
  int total = 0;
  int bad = 0;
  int done_at, n_hs, max_layer;
  int first_pr, first_pc, last_pr, last_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic exp_t blank(input int b, input int rl);
    exp_t e;
    e = '{default: 0};
    e.busy  = b;
    e.relu  = b ? rl : 0;
    e.ready = int'($urandom_range(0, 1));
    return e;
  endfunction

  // Expected trace, one entry per cycle after the start edge.
  task automatic build_trace(input int h, w, sxi, syi, n, rl, mode);
    exp_t e;
    int sx, sy, nr, nc, waits;
    tq.delete();
    sx = (sxi == 0) ? 1 : sxi;
    sy = (syi == 0) ? 1 : syi;
    if (h < 3 || w < 3 || n == 0) begin
      e = blank(1, rl); e.clr = 1; tq.push_back(e);
      e = blank(1, rl); e.done = 1; e.err = 1; tq.push_back(e);
      e = blank(0, rl); e.err = 1; tq.push_back(e);
      return;
    end
    nr = (h - 3) / sy + 1;
    nc = (w - 3) / sx + 1;
    for (int l = 0; l < n; l++)
      for (int r = 0; r < nr; r++)
        for (int c = 0; c < nc; c++) begin
          e = blank(1, rl);
          e.clr = 1; e.pos_care = 1; e.layer = l; e.orow = r; e.ocol = c;
          tq.push_back(e);
          for (int kr = 0; kr < 3; kr++)
            for (int kc = 0; kc < 3; kc++) begin
              e = blank(1, rl);
              e.en = 1; e.pos_care = 1; e.pix_care = 1;
              e.layer = l; e.orow = r; e.ocol = c;
              e.prow = r * sy + kr; e.pcol = c * sx + kc; e.kr = kr; e.kc = kc;
              tq.push_back(e);
            end
          if (mode == 0) waits = 0;
          else if (mode == 2 && l == 0 && r == 0 && c == 0) waits = 20;
          else waits = int'($urandom_range(0, 3));
          for (int i = 0; i <= waits; i++) begin
            e = blank(1, rl);
            e.av = 1; e.pos_care = 1; e.layer = l; e.orow = r; e.ocol = c;
            e.ready = (i == waits) ? 1 : 0;
            tq.push_back(e);
          end
          tq.push_back(blank(1, rl));
        end
    e = blank(1, rl); e.done = 1; tq.push_back(e);
    tq.push_back(blank(0, rl));
  endtask

  task automatic run_cfg(input int h, w, sxi, syi, n, rl, mode);
    exp_t e;
    build_trace(h, w, sxi, syi, n, rl, mode);
    img_h = 6'(h); img_w = 6'(w);
    stride_x = 3'(sxi); stride_y = 3'(syi);
    num_of_conv_layers = 6'(n); relu = 1'(rl);
    start = 1'b1;
    @(posedge clk);
    done_at = -1; n_hs = 0; max_layer = 0;
    first_pr = -1; first_pc = -1; last_pr = -1; last_pc = -1;
    for (int i = 0; i < tq.size(); i++) begin
      e = tq[i];
      @(negedge clk);
      start = e.busy ? 1'($urandom_range(0, 1)) : 1'b0;
      img_h = 6'($urandom); img_w = 6'($urandom);
      stride_x = 3'($urandom); stride_y = 3'($urandom);
      num_of_conv_layers = 6'($urandom); relu = 1'($urandom);
      out_ready = 1'(e.ready);
      check($sformatf("busy@%0d", i), 32'(busy), 32'(e.busy));
      check($sformatf("mac_clr@%0d", i), 32'(mac_clr), 32'(e.clr));
      check($sformatf("mac_en@%0d", i), 32'(mac_en), 32'(e.en));
      check($sformatf("acc_valid@%0d", i), 32'(acc_valid), 32'(e.av));
      check($sformatf("done@%0d", i), 32'(done), 32'(e.done));
      check($sformatf("cfg_err@%0d", i), 32'(cfg_err), 32'(e.err));
      check($sformatf("relu_en@%0d", i), 32'(relu_en), 32'(e.relu));
      if (e.pos_care != 0) begin
        check($sformatf("layer@%0d", i), 32'(layer_idx), 32'(e.layer));
        check($sformatf("out_row@%0d", i), 32'(out_row), 32'(e.orow));
        check($sformatf("out_col@%0d", i), 32'(out_col), 32'(e.ocol));
      end
      if (e.pix_care != 0) begin
        check($sformatf("pix_row@%0d", i), 32'(pix_row), 32'(e.prow));
        check($sformatf("pix_col@%0d", i), 32'(pix_col), 32'(e.pcol));
        check($sformatf("k_row@%0d", i), 32'(k_row), 32'(e.kr));
        check($sformatf("k_col@%0d", i), 32'(k_col), 32'(e.kc));
      end
      if (done && done_at < 0) done_at = i + 1;
      if (acc_valid && out_ready) begin
        n_hs++;
        if (int'(layer_idx) > max_layer) max_layer = int'(layer_idx);
      end
      if (mac_en && out_row == 5'd1 && out_col == 5'd2) begin
        if (k_row == 2'd0 && k_col == 2'd0) begin first_pr = int'(pix_row); first_pc = int'(pix_col); end
        if (k_row == 2'd2 && k_col == 2'd2) begin last_pr = int'(pix_row); last_pc = int'(pix_col); end
      end
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_mac_en"}, 32'(mac_en), 0);
    check({tag, "_mac_clr"}, 32'(mac_clr), 0);
    check({tag, "_acc_valid"}, 32'(acc_valid), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_cfg_err"}, 32'(cfg_err), 0);
    check({tag, "_layer"}, 32'(layer_idx), 0);
    check({tag, "_pix"}, {22'd0, pix_row, pix_col}, 0);
    check({tag, "_k"}, {28'd0, k_row, k_col}, 0);
    check({tag, "_relu_en"}, 32'(relu_en), 0);
  endtask

  initial begin
    int h, w, n;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; relu = 1'b0;
    img_h = '0; img_w = '0; stride_x = '0; stride_y = '0; num_of_conv_layers = '0;
    @(negedge clk);
    check_quiet("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_cfg(5, 5, 1, 1, 1, 1, 0);
    check("done_cycle_5x5", 32'(done_at), 109);
    check("handshakes_5x5", 32'(n_hs), 9);

    run_cfg(7, 7, 2, 2, 1, 0, 1);
    check("w12_first_pix_row", 32'(first_pr), 2);
    check("w12_first_pix_col", 32'(first_pc), 4);
    check("w12_last_pix_row", 32'(last_pr), 4);
    check("w12_last_pix_col", 32'(last_pc), 6);

    run_cfg(6, 5, 0, 3, 2, 1, 1);
    check("handshakes_6x5", 32'(n_hs), 12);
    check("max_layer_6x5", 32'(max_layer), 1);

    run_cfg(6, 6, 1, 1, 1, 0, 2);

    run_cfg(2, 8, 1, 1, 1, 1, 1);
    check("done_cycle_small", 32'(done_at), 2);
    run_cfg(5, 5, 1, 1, 0, 0, 1);
    check("done_cycle_nolayer", 32'(done_at), 2);

    run_cfg(32, 32, 7, 7, 1, 1, 1);
    check("handshakes_32", 32'(n_hs), 25);

    // Reset during the fifth MAC cycle.
    img_h = 6'd5; img_w = 6'd5; stride_x = 3'd1; stride_y = 3'd1;
    num_of_conv_layers = 6'd1; relu = 1'b1; start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_mac_en", 32'(mac_en), 1);
    check("pre_rst_k", {28'd0, k_row, k_col}, 32'h5);
    rst_n = 1'b0;
    #1;
    check_quiet("midrun_rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_done", 32'(done), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_cfg(5, 5, 1, 1, 1, 0, 0);
    check("post_rst_handshakes", 32'(n_hs), 9);

    for (int r = 0; r < 12; r++) begin
      h = int'($urandom_range(1, 10));
      w = int'($urandom_range(1, 10));
      n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3));
      run_cfg(h, w, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), n,
              int'($urandom_range(0, 1)), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
